// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op-code encoding, FSM state
// encoding and small op-classification helpers.
package muldiv_pkg;

  localparam logic [3:0] MD_OP_NOP   = 4'd0;
  localparam logic [3:0] MD_OP_MULT  = 4'd1;
  localparam logic [3:0] MD_OP_MULTU = 4'd2;
  localparam logic [3:0] MD_OP_MADD  = 4'd3;
  localparam logic [3:0] MD_OP_MADDU = 4'd4;
  localparam logic [3:0] MD_OP_MSUB  = 4'd5;
  localparam logic [3:0] MD_OP_MSUBU = 4'd6;
  localparam logic [3:0] MD_OP_DIV   = 4'd7;
  localparam logic [3:0] MD_OP_DIVU  = 4'd8;
  localparam logic [3:0] MD_OP_MTHI  = 4'd9;
  localparam logic [3:0] MD_OP_MTLO  = 4'd10;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } md_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_OP_MULT)  || (op == MD_OP_MULTU) || (op == MD_OP_MADD) ||
           (op == MD_OP_MADDU) || (op == MD_OP_MSUB)  || (op == MD_OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MADD) || (op == MD_OP_MSUB) ||
           (op == MD_OP_DIV);
  endfunction

  // Ops that occupy the unit for more than the accept cycle.
  function automatic logic is_multicycle(input logic [3:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               load dividend/divisor and begin WIDTH iterations
//   abort               stop an in-flight division
//   dividend, divisor   unsigned operands (divisor must be non-zero)
//   last                final iteration in progress; results valid after this edge
//   quotient, remainder results, held until the next start
module muldiv_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic             run_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic [WIDTH:0]   shifted, diff;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dsr_q};
  end

  assign last      = run_q && (cnt_q == CntW'(WIDTH - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (abort) begin
      run_q <= 1'b0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (run_q) begin
      if (diff[WIDTH]) begin
        // Borrow: restore the partial remainder.
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end
      cnt_q <= cnt_q + 1'b1;
      if (last) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i, op_i            request and op code (muldiv_pkg encoding)
//   opa_i, opb_i             operands
//   flush_i                  abort an in-flight op
//   busy_o, done_o           op in flight / one-cycle completion pulse
//   div_by_zero_o            pulses with done_o on divide by zero
//   hi_o, lo_o               HI/LO registers
//   stallreq_o               pipeline stall request (combinational)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stallreq_o
);

  localparam int unsigned CntW    = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam int unsigned MulLast = (MUL_LATENCY >= 2) ? MUL_LATENCY - 2 : 0;

  md_state_e          state_q;
  logic               busy_q, done_q, dbz_q, qneg_q, rneg_q;
  logic [3:0]         op_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] prod_q, prod_comb, a_ext, b_ext;
  logic               sgn, a_neg, b_neg, accept, div_start, div_last;
  logic [WIDTH-1:0]   a_mag, b_mag, div_quo, div_rem, q_fix, r_fix;

  function automatic logic [2*WIDTH-1:0] mul_commit(input logic [3:0] op,
                                                    input logic [2*WIDTH-1:0] acc,
                                                    input logic [2*WIDTH-1:0] p);
    if (op == MD_OP_MADD || op == MD_OP_MADDU) return acc + p;
    if (op == MD_OP_MSUB || op == MD_OP_MSUBU) return acc - p;
    return p;
  endfunction

  always_comb begin
    sgn       = is_signed_op(op_i);
    a_ext     = sgn ? {{WIDTH{opa_i[WIDTH-1]}}, opa_i} : {{WIDTH{1'b0}}, opa_i};
    b_ext     = sgn ? {{WIDTH{opb_i[WIDTH-1]}}, opb_i} : {{WIDTH{1'b0}}, opb_i};
    // Low 2*WIDTH bits of the extended product are correct for both signednesses.
    prod_comb = a_ext * b_ext;
    a_neg     = sgn & opa_i[WIDTH-1];
    b_neg     = sgn & opb_i[WIDTH-1];
    a_mag     = a_neg ? -opa_i : opa_i;
    b_mag     = b_neg ? -opb_i : opb_i;
    q_fix     = qneg_q ? -div_quo : div_quo;
    r_fix     = rneg_q ? -div_rem : div_rem;
  end

  assign accept    = (state_q == StIdle) && start_i && !flush_i;
  assign div_start = accept && is_div_op(op_i) && (opb_i != '0);

  muldiv_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (flush_i),
    .dividend (a_mag),
    .divisor  (b_mag),
    .last     (div_last),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      op_q    <= MD_OP_NOP;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q <= op_i;
            if (is_mul_op(op_i)) begin
              prod_q <= prod_comb;
              cnt_q  <= '0;
              busy_q <= 1'b1;
              if (MUL_LATENCY == 1) begin
                {hi_q, lo_q} <= mul_commit(op_i, {hi_q, lo_q}, prod_comb);
                done_q       <= 1'b1;
                state_q      <= StDone;
              end else begin
                state_q <= StMul;
              end
            end else if (is_div_op(op_i)) begin
              busy_q <= 1'b1;
              if (opb_i == '0) begin
                done_q  <= 1'b1;
                dbz_q   <= 1'b1;
                state_q <= StDone;
              end else begin
                qneg_q  <= a_neg ^ b_neg;
                rneg_q  <= a_neg;
                state_q <= StDiv;
              end
            end else if (op_i == MD_OP_MTHI) begin
              hi_q <= opa_i;
            end else if (op_i == MD_OP_MTLO) begin
              lo_q <= opa_i;
            end
          end
        end
        StMul: begin
          if (flush_i) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (cnt_q == CntW'(MulLast)) begin
            // Accumulate against HI/LO as they stand now, not at accept.
            {hi_q, lo_q} <= mul_commit(op_q, {hi_q, lo_q}, prod_q);
            done_q       <= 1'b1;
            state_q      <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDiv: begin
          if (flush_i) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (div_last) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (flush_i) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            lo_q    <= q_fix;
            hi_q    <= r_fix;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign stallreq_o    = busy_q | (start_i & is_multicycle(op_i) & ~flush_i);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32, MUL_LATENCY=3).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk, rst, start_i, flush_i;
  logic [3:0]  op_i;
  logic [31:0] opa_i, opb_i, hi_o, lo_o;
  logic        busy_o, done_o, div_by_zero_o, stallreq_o;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(
    .WIDTH      (32),
    .MUL_LATENCY(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .op_i         (op_i),
    .opa_i        (opa_i),
    .opb_i        (opb_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .div_by_zero_o(div_by_zero_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo;
    int          cyc;
    logic [31:0] hi, lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance into the next cycle; registered outputs are settled afterwards.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] val);
    start_i = 1'b1;
    op_i    = op;
    opa_i   = val;
    opb_i   = '0;
    next_cycle();
    start_i = 1'b0;
  endtask

  // Issue an op in the current cycle (cycle 0) and wait for done_o.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int dcyc, output logic dbz);
    start_i = 1'b1;
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
    dcyc    = -1;
    dbz     = 1'b0;
    next_cycle();
    start_i = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done_o) begin
        dcyc = c;
        dbz  = div_by_zero_o;
        break;
      end
      next_cycle();
    end
  endtask

  int   dcyc;
  logic dbz;
  logic seen_done;

  initial begin
    vecs[0]  = '{"multu_max",  MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                 3, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{"mult_neg",   MD_OP_MULT,  32'hFFFFFFFD, 32'd7, 32'h0, 32'h0,
                 3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{"maddu_carry", MD_OP_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF,
                 3, 32'h00000001, 32'h00000000, 1'b0};
    vecs[3]  = '{"msub_neg",   MD_OP_MSUB,  32'd2, 32'd3, 32'h0, 32'h0,
                 3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[4]  = '{"madd_signed", MD_OP_MADD, 32'hFFFFFFFE, 32'd3, 32'h0, 32'd10,
                 3, 32'h0, 32'd4, 1'b0};
    vecs[5]  = '{"msubu_borrow", MD_OP_MSUBU, 32'd1, 32'd1, 32'h1, 32'h0,
                 3, 32'h0, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{"mult_minsq", MD_OP_MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0,
                 3, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{"div_neg",    MD_OP_DIV,   32'hFFFFFFF9, 32'd2, 32'h0, 32'h0,
                 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{"divu_100_7", MD_OP_DIVU,  32'd100, 32'd7, 32'h0, 32'h0,
                 34, 32'd2, 32'd14, 1'b0};
    vecs[9]  = '{"div_negdsr", MD_OP_DIV,   32'd7, 32'hFFFFFFFE, 32'h0, 32'h0,
                 34, 32'd1, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{"div_min_m1", MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6,
                 34, 32'h0, 32'h80000000, 1'b0};
    vecs[11] = '{"divu_big",   MD_OP_DIVU,  32'hFFFFFFFF, 32'h10, 32'h0, 32'h0,
                 34, 32'hF, 32'h0FFFFFFF, 1'b0};
    vecs[12] = '{"divu_zero",  MD_OP_DIVU,  32'd100, 32'd0, 32'h1234, 32'h5678,
                 1, 32'h1234, 32'h5678, 1'b1};

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = MD_OP_NOP; opa_i = '0; opb_i = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    check("reset_outputs", {30'd0, hi_o, lo_o, busy_o, done_o},   64'd0);
    check("reset_flags",   {62'd0, div_by_zero_o, stallreq_o},    64'd0);

    // Table-driven main function checks.
    for (int i = 0; i < 13; i++) begin
      move_to(MD_OP_MTHI, vecs[i].pre_hi);
      move_to(MD_OP_MTLO, vecs[i].pre_lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, dcyc, dbz);
      check({vecs[i].name, "_cycle"}, 64'(dcyc), 64'(vecs[i].cyc));
      check({vecs[i].name, "_hi"},  {32'd0, hi_o}, {32'd0, vecs[i].hi});
      check({vecs[i].name, "_lo"},  {32'd0, lo_o}, {32'd0, vecs[i].lo});
      check({vecs[i].name, "_dbz"}, {63'd0, dbz},  {63'd0, vecs[i].dbz});
      next_cycle();
      check({vecs[i].name, "_after"}, {62'd0, done_o, busy_o}, 64'd0);
    end

    // MTHI is single-cycle: no stall, no busy, no done.
    start_i = 1'b1; op_i = MD_OP_MTHI; opa_i = 32'hCAFE0001; #1;
    check("mthi_stall", {63'd0, stallreq_o}, 64'd0);
    next_cycle();
    start_i = 1'b0;
    check("mthi_value", {32'd0, hi_o}, {32'd0, 32'hCAFE0001});
    check("mthi_nobusy", {62'd0, busy_o, done_o}, 64'd0);

    // stallreq_o for MULTU across cycles 0..4.
    start_i = 1'b1; op_i = MD_OP_MULTU; opa_i = 32'd3; opb_i = 32'd5; #1;
    check("stall_c0", {63'd0, stallreq_o}, 64'd1);
    next_cycle();
    start_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("stall_c%0d", c), {63'd0, stallreq_o}, (c <= 3) ? 64'd1 : 64'd0);
      next_cycle();
    end

    // Flush a DIV in cycle 10; a start in cycle 11 must be accepted.
    move_to(MD_OP_MTHI, 32'hAAAA);
    move_to(MD_OP_MTLO, 32'hBBBB);
    start_i = 1'b1; op_i = MD_OP_DIV; opa_i = 32'd50; opb_i = 32'd3;
    seen_done = 1'b0;
    next_cycle();
    start_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      seen_done |= done_o;
      if (c == 10) flush_i = 1'b1;
      else next_cycle();
    end
    next_cycle();
    flush_i = 1'b0;
    seen_done |= done_o;
    check("flush_busy", {63'd0, busy_o}, 64'd0);
    check("flush_nodone", {63'd0, seen_done}, 64'd0);
    check("flush_hilo", {hi_o, lo_o}, {32'hAAAA, 32'hBBBB});
    run_op(MD_OP_MULTU, 32'd2, 32'd3, dcyc, dbz);
    check("after_flush_cycle", 64'(dcyc), 64'd3);
    check("after_flush_lo", {hi_o, lo_o}, 64'd6);
    next_cycle();

    // start_i while busy is ignored.
    start_i = 1'b1; op_i = MD_OP_DIVU; opa_i = 32'd100; opb_i = 32'd7;
    dcyc = -1;
    next_cycle();
    start_i = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin start_i = 1'b1; op_i = MD_OP_MULTU; opa_i = 32'd5; opb_i = 32'd5; end
      if (c == 6) start_i = 1'b0;
      if (done_o) begin dcyc = c; break; end
      next_cycle();
    end
    check("busy_ignore_cycle", 64'(dcyc), 64'd34);
    check("busy_ignore_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
    next_cycle();
    check("busy_ignore_idle", {62'd0, busy_o, done_o}, 64'd0);

    // start_i together with flush_i: nothing accepted.
    move_to(MD_OP_MTLO, 32'h77);
    start_i = 1'b1; flush_i = 1'b1; op_i = MD_OP_MULTU; opa_i = 32'd3; opb_i = 32'd3; #1;
    check("startflush_stall", {63'd0, stallreq_o}, 64'd0);
    next_cycle();
    start_i = 1'b0; flush_i = 1'b0;
    seen_done = 1'b0;
    check("startflush_busy", {63'd0, busy_o}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      seen_done |= done_o;
      next_cycle();
    end
    check("startflush_nodone", {63'd0, seen_done}, 64'd0);
    check("startflush_lo", {32'd0, lo_o}, 64'h77);

    // Reset in cycle 5 of a DIV clears everything.
    move_to(MD_OP_MTHI, 32'h99);
    start_i = 1'b1; op_i = MD_OP_DIV; opa_i = 32'hFFFFFFF9; opb_i = 32'd2;
    next_cycle();
    start_i = 1'b0;
    for (int c = 1; c < 5; c++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("midrst_hilo", {hi_o, lo_o}, 64'd0);
    check("midrst_flags", {61'd0, busy_o, done_o, div_by_zero_o}, 64'd0);
    run_op(MD_OP_DIVU, 32'd100, 32'd7, dcyc, dbz);
    check("postrst_div", {hi_o, lo_o}, {32'd2, 32'd14});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
